// File: rtl/toy_bus_ddec_node_param.sv
// Address-decoding request node with round-robin ack return, outstanding limit and local error acks.
// Optional in-order mode: define TOY_BUS_DEC_ORDER_EN.
module toy_bus_ddec_node_param #(
  parameter int unsigned N_OUT     = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned SEL_LSB   = 28,
  parameter int unsigned MAX_OUTST = 4,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_req_vld,
  output logic                       in_req_rdy,
  input  logic [ADDR_W-1:0]          in_req_addr,
  input  logic [DATA_W/8-1:0]        in_req_strb,
  input  logic [DATA_W-1:0]          in_req_data,
  input  logic                       in_req_opcode,
  input  logic [ID_W-1:0]            in_req_src_id,
  input  logic [ID_W-1:0]            in_req_tgt_id,
  output logic                       in_ack_vld,
  input  logic                       in_ack_rdy,
  output logic                       in_ack_opcode,
  output logic [DATA_W-1:0]          in_ack_data,
  output logic [ID_W-1:0]            in_ack_src_id,
  output logic [ID_W-1:0]            in_ack_tgt_id,
  output logic [N_OUT-1:0]           out_req_vld,
  input  logic [N_OUT-1:0]           out_req_rdy,
  output logic [N_OUT*ADDR_W-1:0]    out_req_addr,
  output logic [N_OUT*DATA_W/8-1:0]  out_req_strb,
  output logic [N_OUT*DATA_W-1:0]    out_req_data,
  output logic [N_OUT-1:0]           out_req_opcode,
  output logic [N_OUT*ID_W-1:0]      out_req_src_id,
  output logic [N_OUT*ID_W-1:0]      out_req_tgt_id,
  input  logic [N_OUT-1:0]           out_ack_vld,
  output logic [N_OUT-1:0]           out_ack_rdy,
  input  logic [N_OUT-1:0]           out_ack_opcode,
  input  logic [N_OUT*DATA_W-1:0]    out_ack_data,
  input  logic [N_OUT*ID_W-1:0]      out_ack_src_id,
  input  logic [N_OUT*ID_W-1:0]      out_ack_tgt_id
);

  localparam int unsigned SEL_W = $clog2(N_OUT);
  localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);
  localparam logic [SEL_W:0]   N_OUT_C = (SEL_W + 1)'(N_OUT);
  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_OUTST);

  logic [SEL_W-1:0] tgt;
  logic             mapped;
  logic             order_ok;
  logic             miss_order_ok;
  logic             issue_ok;
  logic             slot_free;
  logic             any_ack;
  logic             fwd_hs;
  logic             miss_hs;
  logic             ack_hs;
  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] rr_next;
  logic [SEL_W-1:0] gnt_idx;
  logic             gnt_vld;
  logic [SEL_W:0]   scan;
  logic [N_OUT-1:0] grant;
  logic             sel_opcode;
  logic [DATA_W-1:0] sel_data;
  logic [ID_W-1:0]   sel_src_id;
  logic [ID_W-1:0]   sel_tgt_id;

  assign tgt       = in_req_addr[SEL_LSB +: SEL_W];
  assign mapped    = {1'b0, tgt} < N_OUT_C;
  assign slot_free = ~in_ack_vld | in_ack_rdy;
  assign any_ack   = |out_ack_vld;

`ifdef TOY_BUS_DEC_ORDER_EN
  logic [SEL_W-1:0] cur_tgt;

  assign order_ok      = (cnt == '0) | (tgt == cur_tgt);
  assign miss_order_ok = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_tgt <= '0;
    end else if (fwd_hs) begin
      cur_tgt <= tgt;
    end
  end
`else
  assign order_ok      = 1'b1;
  assign miss_order_ok = 1'b1;
`endif

  assign issue_ok = (cnt < MAX_C) & order_ok;

  always_comb begin
    in_req_rdy  = 1'b0;
    out_req_vld = '0;
    if (!mapped) begin
      // returned acks own the slot ahead of local error acks
      in_req_rdy = slot_free & ~any_ack & miss_order_ok;
    end else begin
      for (int unsigned i = 0; i < N_OUT; i++) begin
        if (tgt == SEL_W'(i)) begin
          in_req_rdy     = out_req_rdy[i] & issue_ok;
          out_req_vld[i] = in_req_vld & issue_ok;
        end
      end
    end
  end

  assign fwd_hs  = in_req_vld & in_req_rdy & mapped;
  assign miss_hs = in_req_vld & in_req_rdy & ~mapped;

  assign out_req_addr   = {N_OUT{in_req_addr}};
  assign out_req_strb   = {N_OUT{in_req_strb}};
  assign out_req_data   = {N_OUT{in_req_data}};
  assign out_req_opcode = {N_OUT{in_req_opcode}};
  assign out_req_src_id = {N_OUT{in_req_src_id}};
  assign out_req_tgt_id = {N_OUT{in_req_tgt_id}};

  // scan indices stay below 2*N_OUT, so a single conditional subtract wraps them
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    scan    = '0;
    for (int unsigned k = 0; k < N_OUT; k++) begin
      scan = {1'b0, rr_ptr} + (SEL_W + 1)'(k);
      if (scan >= N_OUT_C) begin
        scan = scan - N_OUT_C;
      end
      if (!gnt_vld && out_ack_vld[scan[SEL_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan[SEL_W-1:0];
      end
    end
  end

  always_comb begin
    grant      = '0;
    sel_opcode = 1'b0;
    sel_data   = '0;
    sel_src_id = '0;
    sel_tgt_id = '0;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      grant[i] = gnt_vld & (gnt_idx == SEL_W'(i));
      if (grant[i]) begin
        sel_opcode = out_ack_opcode[i];
        sel_data   = out_ack_data[i*DATA_W +: DATA_W];
        sel_src_id = out_ack_src_id[i*ID_W +: ID_W];
        sel_tgt_id = out_ack_tgt_id[i*ID_W +: ID_W];
      end
    end
  end

  assign out_ack_rdy = grant & {N_OUT{slot_free}};
  assign ack_hs      = gnt_vld & slot_free;
  assign rr_next     = (gnt_idx == SEL_W'(N_OUT - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ack_vld    <= 1'b0;
      in_ack_opcode <= 1'b0;
      in_ack_data   <= '0;
      in_ack_src_id <= '0;
      in_ack_tgt_id <= '0;
      rr_ptr        <= '0;
    end else if (ack_hs) begin
      in_ack_vld    <= 1'b1;
      in_ack_opcode <= sel_opcode;
      in_ack_data   <= sel_data;
      in_ack_src_id <= sel_src_id;
      in_ack_tgt_id <= sel_tgt_id;
      rr_ptr        <= rr_next;
    end else if (miss_hs) begin
      in_ack_vld    <= 1'b1;
      in_ack_opcode <= in_req_opcode;
      in_ack_data   <= ERR_DATA;
      in_ack_src_id <= in_req_tgt_id;
      in_ack_tgt_id <= in_req_src_id;
    end else if (slot_free) begin
      in_ack_vld    <= 1'b0;
    end
  end

  // acks may arrive with nothing counted (e.g. after reset); count floors at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (fwd_hs && !ack_hs) begin
      cnt <= cnt + 1'b1;
    end else if (!fwd_hs && ack_hs && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_toy_bus_ddec_node_param.sv
// Directed and randomized bench for toy_bus_ddec_node_param (N_OUT=3) against a behavioural model.
module tb_toy_bus_ddec_node_param;
  localparam int N    = 3;
  localparam int MAXO = 4;

  logic          clk;
  logic          rst_n;
  logic          in_req_vld;
  logic          in_req_rdy;
  logic [31:0]   in_req_addr;
  logic [3:0]    in_req_strb;
  logic [31:0]   in_req_data;
  logic          in_req_opcode;
  logic [3:0]    in_req_src_id;
  logic [3:0]    in_req_tgt_id;
  logic          in_ack_vld;
  logic          in_ack_rdy;
  logic          in_ack_opcode;
  logic [31:0]   in_ack_data;
  logic [3:0]    in_ack_src_id;
  logic [3:0]    in_ack_tgt_id;
  logic [N-1:0]  out_req_vld;
  logic [N-1:0]  out_req_rdy;
  logic [N*32-1:0] out_req_addr;
  logic [N*4-1:0]  out_req_strb;
  logic [N*32-1:0] out_req_data;
  logic [N-1:0]    out_req_opcode;
  logic [N*4-1:0]  out_req_src_id;
  logic [N*4-1:0]  out_req_tgt_id;
  logic [N-1:0]    out_ack_vld;
  logic [N-1:0]    out_ack_rdy;
  logic [N-1:0]    out_ack_opcode;
  logic [N*32-1:0] out_ack_data;
  logic [N*4-1:0]  out_ack_src_id;
  logic [N*4-1:0]  out_ack_tgt_id;

  int tests = 0;
  int fails = 0;

  // reference state
  int         m_cnt, m_ptr, m_cur;
  bit         m_avld;
  logic       m_aop;
  logic [31:0] m_adata;
  logic [3:0]  m_asrc, m_atgt;
  int         n_cnt, n_ptr, n_cur;
  bit         n_avld;
  logic       n_aop;
  logic [31:0] n_adata;
  logic [3:0]  n_asrc, n_atgt;

  toy_bus_ddec_node_param #(.N_OUT(N), .MAX_OUTST(MAXO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_req_vld(in_req_vld), .in_req_rdy(in_req_rdy), .in_req_addr(in_req_addr),
    .in_req_strb(in_req_strb), .in_req_data(in_req_data), .in_req_opcode(in_req_opcode),
    .in_req_src_id(in_req_src_id), .in_req_tgt_id(in_req_tgt_id),
    .in_ack_vld(in_ack_vld), .in_ack_rdy(in_ack_rdy), .in_ack_opcode(in_ack_opcode),
    .in_ack_data(in_ack_data), .in_ack_src_id(in_ack_src_id), .in_ack_tgt_id(in_ack_tgt_id),
    .out_req_vld(out_req_vld), .out_req_rdy(out_req_rdy), .out_req_addr(out_req_addr),
    .out_req_strb(out_req_strb), .out_req_data(out_req_data), .out_req_opcode(out_req_opcode),
    .out_req_src_id(out_req_src_id), .out_req_tgt_id(out_req_tgt_id),
    .out_ack_vld(out_ack_vld), .out_ack_rdy(out_ack_rdy), .out_ack_opcode(out_ack_opcode),
    .out_ack_data(out_ack_data), .out_ack_src_id(out_ack_src_id), .out_ack_tgt_id(out_ack_tgt_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_ptr = 0; m_cur = 0; m_avld = 0;
    m_aop = 1'b0; m_adata = '0; m_asrc = '0; m_atgt = '0;
  endtask

  // settle inputs, compare DUT against the model, and compute the model's next state
  task automatic settle_check();
    int t, g;
    bit mapped, ook, moo, free, any_ack, issue, exp_rdy, inc, dec;
    logic [N-1:0] exp_ovld, exp_ardy;
    #1;
    t = int'(in_req_addr >> 28) % 4;
    mapped = t < N;
`ifdef TOY_BUS_DEC_ORDER_EN
    ook = (m_cnt == 0) || (t == m_cur);
    moo = (m_cnt == 0);
`else
    ook = 1; moo = 1;
`endif
    free    = !m_avld || in_ack_rdy;
    any_ack = out_ack_vld != '0;
    exp_ovld = '0;
    if (mapped) begin
      issue   = (m_cnt < MAXO) && ook;
      exp_rdy = out_req_rdy[t] && issue;
      if (in_req_vld && issue) exp_ovld[t] = 1'b1;
    end else begin
      exp_rdy = free && !any_ack && moo;
    end
    g = -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (g < 0 && out_ack_vld[i]) g = i;
    end
    exp_ardy = '0;
    if (g >= 0 && free) exp_ardy[g] = 1'b1;

    chk("in_req_rdy", in_req_rdy, exp_rdy);
    chk("out_req_vld", out_req_vld, exp_ovld);
    chk("out_ack_rdy", out_ack_rdy, exp_ardy);
    chk("in_ack_vld", in_ack_vld, m_avld);
    if (m_avld) begin
      chk("ack_opcode", in_ack_opcode, m_aop);
      chk("ack_data", in_ack_data, m_adata);
      chk("ack_src", in_ack_src_id, m_asrc);
      chk("ack_tgt", in_ack_tgt_id, m_atgt);
    end
    if (exp_ovld != '0) begin
      chk("fwd_addr", out_req_addr[t*32 +: 32], in_req_addr);
      chk("fwd_data", out_req_data[t*32 +: 32], in_req_data);
      chk("fwd_ids", {out_req_src_id[t*4 +: 4], out_req_tgt_id[t*4 +: 4]}, {in_req_src_id, in_req_tgt_id});
    end

    n_cnt = m_cnt; n_ptr = m_ptr; n_cur = m_cur; n_avld = m_avld;
    n_aop = m_aop; n_adata = m_adata; n_asrc = m_asrc; n_atgt = m_atgt;
    dec = (g >= 0) && free;
    inc = in_req_vld && exp_rdy && mapped;
    if (dec) begin
      n_avld = 1; n_aop = out_ack_opcode[g]; n_adata = out_ack_data[g*32 +: 32];
      n_asrc = out_ack_src_id[g*4 +: 4]; n_atgt = out_ack_tgt_id[g*4 +: 4];
      n_ptr = (g + 1) % N;
    end else if (in_req_vld && exp_rdy && !mapped) begin
      n_avld = 1; n_aop = in_req_opcode; n_adata = 32'hDEAD_BEEF;
      n_asrc = in_req_tgt_id; n_atgt = in_req_src_id;
    end else if (free) begin
      n_avld = 0;
    end
    n_cnt = m_cnt + int'(inc) - int'(dec);
    if (n_cnt < 0) n_cnt = 0;
    if (inc) n_cur = t;
  endtask

  task automatic advance();
    m_cnt = n_cnt; m_ptr = n_ptr; m_cur = n_cur; m_avld = n_avld;
    m_aop = n_aop; m_adata = n_adata; m_asrc = n_asrc; m_atgt = n_atgt;
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    settle_check();
    advance();
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    in_req_vld = 1'b0;
    out_ack_vld = '0;
    #1;
    chk("rst_ack_vld", in_ack_vld, 1'b0);
    chk("rst_cnt", dut.cnt, 0);
    chk("rst_rr_ptr", dut.rr_ptr, 0);
    chk("rst_out_req_vld", out_req_vld, '0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    rst_n = 1'b0;
    in_req_vld = 0; in_req_addr = '0; in_req_strb = 4'hF; in_req_data = '0;
    in_req_opcode = 0; in_req_src_id = '0; in_req_tgt_id = '0;
    in_ack_rdy = 1; out_req_rdy = '0; out_ack_vld = '0; out_ack_opcode = '0;
    out_ack_data = '0; out_ack_src_id = '0; out_ack_tgt_id = '0;
    model_reset();
    reset_dut();

    // decode to target 2
    d = $urandom;
    in_req_vld = 1; in_req_addr = 32'h2000_0010; in_req_data = d;
    in_req_src_id = 4'd3; in_req_tgt_id = 4'd6; out_req_rdy = '1;
    settle_check();
    chk("dec_vld", out_req_vld, 3'b100);
    chk("dec_addr", out_req_addr[64 +: 32], 32'h2000_0010);
    chk("dec_data", out_req_data[64 +: 32], d);
    advance();
    in_req_vld = 0;
    out_ack_vld = 3'b100; out_ack_data[64 +: 32] = 32'h1234_5678; out_ack_src_id[8 +: 4] = 4'd2;
    step();
    out_ack_vld = '0;
    settle_check();
    chk("ack_latency_vld", in_ack_vld, 1'b1);
    chk("ack_latency_data", in_ack_data, 32'h1234_5678);
    advance();
    chk("cnt_after_ack", dut.cnt, 0);

    // outstanding limit
    reset_dut();
    in_req_vld = 1; in_req_addr = 32'h1000_0000; out_req_rdy = '1; in_ack_rdy = 1;
    for (int j = 0; j < 5; j++) begin
      settle_check();
      chk("outst_rdy", in_req_rdy, (j < 4) ? 1'b1 : 1'b0);
      advance();
    end
    out_ack_vld = 3'b010;
    settle_check();
    chk("outst_full_rdy", in_req_rdy, 1'b0);
    chk("outst_ack_rdy", out_ack_rdy, 3'b010);
    advance();
    out_ack_vld = '0;
    settle_check();
    chk("outst_resume", in_req_rdy, 1'b1);
    advance();
    in_req_vld = 0;
    step();
    chk("cnt_max", dut.cnt, MAXO);

    // round robin with all acks pending
    reset_dut();
    for (int i = 0; i < N; i++) begin
      out_ack_src_id[i*4 +: 4] = 4'(i);
      out_ack_tgt_id[i*4 +: 4] = 4'(i + 8);
      out_ack_data[i*32 +: 32] = 32'(100 + i);
    end
    out_ack_vld = '1; in_ack_rdy = 1;
    for (int c = 0; c < 5; c++) begin
      settle_check();
      if (c > 0) chk("rr_src_seq", in_ack_src_id, 4'((c - 1) % N));
      advance();
    end
    in_ack_rdy = 0;
    for (int c = 0; c < 3; c++) begin
      settle_check();
      chk("rr_hold_rdy", out_ack_rdy, '0);
      chk("rr_hold_src", in_ack_src_id, 4'd1);
      chk("rr_hold_data", in_ack_data, 32'd101);
      advance();
    end
    in_ack_rdy = 1;
    step();
    chk("rr_resume_src", in_ack_src_id, 4'd2);
    chk("rr_cnt_floor", dut.cnt, 0);

    // unmapped address
    reset_dut();
    in_ack_rdy = 1; out_ack_vld = '0;
    in_req_vld = 1; in_req_addr = 32'h3000_0000; in_req_src_id = 4'd5; in_req_tgt_id = 4'd9;
    in_req_opcode = 1;
    settle_check();
    chk("miss_no_fwd", out_req_vld, '0);
    chk("miss_rdy", in_req_rdy, 1'b1);
    advance();
    in_req_vld = 0;
    settle_check();
    chk("miss_ack", {in_ack_vld, in_ack_data, in_ack_src_id, in_ack_tgt_id},
        {1'b1, 32'hDEAD_BEEF, 4'd9, 4'd5});
    advance();
    in_req_vld = 1; out_ack_vld = 3'b001;
    settle_check();
    chk("miss_blocked", in_req_rdy, 1'b0);
    advance();
    in_req_vld = 0; out_ack_vld = '0;
    step();

    // second target while first is outstanding
    reset_dut();
    in_req_vld = 1; in_req_addr = 32'h0000_0040; out_req_rdy = '1;
    step();
    in_req_addr = 32'h1000_0040;
    settle_check();
`ifdef TOY_BUS_DEC_ORDER_EN
    chk("order_block", out_req_vld, 3'b000);
`else
    chk("order_free", out_req_vld, 3'b010);
`endif
    advance();
    in_req_vld = 0;
    step();

    // randomized traffic with a reset in the middle
    for (int c = 0; c < 600; c++) begin
      if (c == 300) reset_dut();
      in_req_vld    = $urandom_range(0, 1) == 1;
      in_req_addr   = $urandom;
      in_req_strb   = 4'($urandom);
      in_req_data   = $urandom;
      in_req_opcode = 1'($urandom);
      in_req_src_id = 4'($urandom);
      in_req_tgt_id = 4'($urandom);
      out_req_rdy   = 3'($urandom);
      out_ack_vld   = ($urandom_range(0, 2) == 0) ? 3'($urandom) : '0;
      out_ack_opcode = 3'($urandom);
      out_ack_data  = {$urandom, $urandom, $urandom};
      out_ack_src_id = 12'($urandom);
      out_ack_tgt_id = 12'($urandom);
      in_ack_rdy    = $urandom_range(0, 3) != 0;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
